// File: rtl/muldiv_sequencer.sv
// R3000 multiply/divide sequencer: owns HI/LO, computes at accept, commits after the PSX latency.
// Build option: MULDIV_EARLY_OUT_EN enables operand-dependent multiply latency tiers.
module muldiv_sequencer #(
  parameter int DIV_LATENCY   = 36,
  parameter int MUL_LAT_SHORT = 6,
  parameter int MUL_LAT_MID   = 9,
  parameter int MUL_LAT_LONG  = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        rd_hi_req,
  input  logic        rd_lo_req,
  output logic        rd_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] p_hi, p_lo;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;
  logic [5:0]  lat, mul_lat;

  assign op_ready = (state == S_IDLE);
  assign busy     = (state == S_RUN);
  assign rd_stall = busy && (rd_hi_req || rd_lo_req);
  assign accept   = op_valid && op_ready && (op_code <= OP_MTLO);

  assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  assign a_neg = (op_code == OP_DIV) && op_a[31];
  assign b_neg = (op_code == OP_DIV) && op_b[31];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    mul_lat = 6'(MUL_LAT_LONG);
    if (op_code == OP_MULT) begin
      if ((&op_a[31:11]) || ~(|op_a[31:11]))      mul_lat = 6'(MUL_LAT_SHORT);
      else if ((&op_a[31:20]) || ~(|op_a[31:20])) mul_lat = 6'(MUL_LAT_MID);
    end else begin
      if (~(|op_a[31:11]))      mul_lat = 6'(MUL_LAT_SHORT);
      else if (~(|op_a[31:20])) mul_lat = 6'(MUL_LAT_MID);
    end
  end
`else
  assign mul_lat = 6'(MUL_LAT_LONG);
`endif

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    lat    = 6'(DIV_LATENCY);
    case (op_code)
      OP_MULT:  begin {res_hi, res_lo} = prod_s; lat = mul_lat; end
      OP_MULTU: begin {res_hi, res_lo} = prod_u; lat = mul_lat; end
      OP_DIV, OP_DIVU: begin
        if (op_b == 32'd0) begin
          res_hi = op_a;
          res_lo = a_neg ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else begin
          res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
          res_hi = a_neg ? -r_mag : r_mag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 6'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op_code)
              OP_MTHI: hi <= op_a;
              OP_MTLO: lo <= op_a;
              default: begin
                p_hi  <= res_hi;
                p_lo  <= res_lo;
                cnt   <= lat - 6'd1;
                state <= S_RUN;
              end
            endcase
          end
        end
        S_RUN: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            hi    <= p_hi;
            lo    <= p_lo;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes model results, monitor checks commits and busy length.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        op_ready, rd_hi_req, rd_lo_req, rd_stall, busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req), .rd_stall(rd_stall),
    .hi(hi), .lo(lo), .busy(busy)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          chk_lat;
  } exp_t;

  exp_t        q[$];
  int          compared = 0, mismatched = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Latency tiers expressed as value ranges of op_a.
  function automatic int mul_lat(bit sgn, logic [31:0] a);
    longint v;
    int     t;
    v = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    if (v >= -2048 && v < 2048)             t = 6;
    else if (v >= -1048576 && v < 1048576)  t = 9;
    else                                    t = 13;
`ifndef MULDIV_EARLY_OUT_EN
    t = 13;
`endif
    return t;
  endfunction

  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    longint      sa, sb, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.hi = m_hi; e.lo = m_lo; e.lat = 1; e.chk_lat = 1'b1;
    case (op)
      3'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = mul_lat(1'b1, a); end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; e.hi = pu[63:32]; e.lo = pu[31:0]; e.lat = mul_lat(1'b0, a); end
      3'd2: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = (sa < 0) ? 32'h1 : 32'hFFFF_FFFF;
        end else begin
          p = sa / sb; e.lo = p[31:0];
          p = sa % sb; e.hi = p[31:0];
        end
        e.lat = 36;
      end
      3'd3: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
        else begin e.lo = a / b; e.hi = a % b; end
        e.lat = 36;
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  // Called at a negedge; returns at a negedge with op_valid dropped.
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int   t;
    exp_t e;
    t = 0;
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b;
    if (op > 3'd5) begin
      @(negedge clk);
      op_valid = 1'b0;
    end else begin
      while (!op_ready && t < 200) begin @(negedge clk); t++; end
      if (!op_ready) begin
        compared++; mismatched++;
        $display("FAIL issue_timeout: op_ready stayed %b expected 1", op_ready);
        op_valid = 1'b0;
      end else begin
        e = model(op, a, b);
        m_hi = e.hi; m_lo = e.lo;
        q.push_back(e);
        @(negedge clk);
        op_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 1000) begin @(negedge clk); t++; end
  endtask

  // Monitor: sees an accept, counts busy cycles, checks the first idle cycle.
  initial begin
    int   nb;
    exp_t e;
    @(negedge clk); #4;
    forever begin
      if (op_valid && op_ready && op_code <= 3'd5 && !rst) begin
        @(posedge clk);
        nb = 0;
        @(negedge clk); #4;
        while (busy && nb < 100) begin nb++; @(negedge clk); #4; end
        if (q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_accept: queue empty at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
          chk("ready_after", {31'd0, op_ready}, 32'd1);
          if (e.chk_lat) chk("busy_cycles", nb, e.lat - 1);
        end
      end else begin
        @(negedge clk); #4;
      end
    end
  end

  // Random MFHI/MFLO requests; stall must track busy in the same cycle.
  initial begin
    rd_hi_req = 1'b0; rd_lo_req = 1'b0;
    forever begin
      @(negedge clk);
      rd_hi_req = ($urandom % 3 == 0);
      rd_lo_req = ($urandom % 3 == 0);
      #4;
      chk("rd_stall", {31'd0, rd_stall}, {31'd0, busy && (rd_hi_req || rd_lo_req)});
    end
  end

  initial begin
    #800000;
    mismatched++;
    $display("FAIL watchdog: run did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    exp_t        r;
    rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, op_ready}, 32'd1);
    rst = 1'b0;

    issue(3'd1, 32'h0000_07FF, 32'd3);
    issue(3'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    issue(3'd0, 32'h0000_0400, 32'd5);
    issue(3'd0, 32'hFFF0_0000, 32'd7);
    issue(3'd1, 32'h000F_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd2, 32'd5, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFF0, 32'd7);
    issue(3'd3, 32'h1234_5678, 32'd0);
    issue(3'd0, 32'hCAFE_0001, 32'h8000_0000);
    wait_idle();
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    issue(3'd3, 32'd1000, 32'd9);
    issue(3'd5, 32'h1357_9BDF, 32'd0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd1);
    issue(3'd7, 32'hFFFF_FFFF, 32'd1);
    wait_idle();

    // Reset in the middle of a divide discards the pending result.
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q.delete();
    r.hi = 32'd0; r.lo = 32'd0; r.lat = 0; r.chk_lat = 1'b0;
    q.push_back(r);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_late_hi", hi, m_hi);
    chk("no_late_lo", lo, m_lo);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom % 5)
        0: a = $urandom;
        1: a = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: a = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        3: a = 32'h8000_0000;
        default: a = $urandom % 2048;
      endcase
      case ($urandom % 5)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom % 16;
        default: b = $urandom;
      endcase
      issue(op, a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
